// File: rtl/jk_counter_pkg.sv
// Shared JK encodings and compare helper for the JK-cell mod-N counter.
package jk_counter_pkg;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  function automatic logic in_range(input int unsigned v, input int unsigned modulus);
    return v < modulus;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop storage cell, asynchronous active-low clear.
module jk_cell
  import jk_counter_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        JK_HOLD: q <= q;
        JK_RST:  q <= 1'b0;
        JK_SET:  q <= 1'b1;
        default: q <= ~q;
      endcase
    end
  end

endmodule

// File: rtl/jk_mod_counter.sv
// Mod-N up/down counter: J/K steering in front of a chain of jk_cell instances.
// Define JK_MOD_COUNTER_SATURATE_EN to hold at the end points instead of wrapping.
module jk_mod_counter
  import jk_counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 10
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             load_err
);

  if ((MODULUS < 2) || ((WIDTH < 32) && (MODULUS > (32'd1 << WIDTH)))) begin : g_bad_modulus
    $error("jk_mod_counter: MODULUS must lie in 2..2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0]      nxt;
  logic [WIDTH-1:0][1:0] jk;
  logic                  load_ok;

  assign load_ok = in_range(32'(load_val), MODULUS);

  // Next value: wrap/saturate is an explicit compare, never natural overflow
  always_comb begin
    nxt = count;
    if (load) begin
      nxt = load_ok ? load_val : '0;
    end else if (en) begin
      if (up_dn) begin
        if (count == MAX_VAL) begin
`ifdef JK_MOD_COUNTER_SATURATE_EN
          nxt = MAX_VAL;
`else
          nxt = '0;
`endif
        end else begin
          nxt = count + ONE;
        end
      end else begin
        if (count == '0) begin
`ifdef JK_MOD_COUNTER_SATURATE_EN
          nxt = '0;
`else
          nxt = MAX_VAL;
`endif
        end else begin
          nxt = count - ONE;
        end
      end
    end
  end

  // Loads use set/reset encoding; counting toggles only the bits that change
  always_comb begin
    jk = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (load) begin
        jk[i] = nxt[i] ? JK_SET : JK_RST;
      end else begin
        jk[i] = (count[i] ^ nxt[i]) ? JK_TGL : JK_HOLD;
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell u_cell (
      .clock   (clock),
      .reset_n (reset_n),
      .j       (jk[i][1]),
      .k       (jk[i][0]),
      .q       (count[i])
    );
  end

  assign tc = en & ~load & ((up_dn & (count == MAX_VAL)) | (~up_dn & (count == '0)));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      load_err <= 1'b0;
    end else begin
      load_err <= load & ~load_ok;
    end
  end

endmodule
